// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key codes, scan-result and debounce encodings, keymap.
package keypad_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_DIV = 4'hC;
    localparam logic [3:0] KEY_MUL = 4'hD;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_ONE   = 2'd1,
        RES_MULTI = 2'd2
    } scan_kind_e;

    // One published full-scan result; valid for a single cycle.
    typedef struct packed {
        logic       valid;
        scan_kind_e kind;
        logic [3:0] code;
    } scan_result_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAND = 2'd1,
        ST_HELD = 2'd2,
        ST_REL  = 2'd3
    } db_state_e;

    // Physical (row, column) position to key code.
    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = KEY_ADD;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = KEY_SUB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = KEY_DIV;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            4'hF: code = KEY_MUL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// keypad_scanner: walks the columns, synchronizes rows, and publishes one
// NONE/ONE/MULTI result per complete four-column scan.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   row,
    output logic [3:0]   col,
    output scan_result_t result
);

    localparam int unsigned DWELL_W = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);

    logic [3:0]         row_meta;
    logic [3:0]         row_sync;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         col_idx;
    logic [1:0]         acc_keys;    // keys seen so far this scan, saturating at 2
    logic [3:0]         acc_code;

    logic               sample;
    logic [3:0]         lows;
    logic [2:0]         col_keys;
    logic [1:0]         row_idx;
    logic [1:0]         base_keys;
    logic [2:0]         sum_keys;
    logic [1:0]         scan_keys;
    logic [3:0]         scan_code;
    scan_kind_e         scan_kind;

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Dwell counter and column drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell   <= '0;
            col_idx <= 2'd0;
            col     <= 4'b1110;
        end else if (sample) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            col     <= ~(4'b0001 << (col_idx + 2'd1));
        end else begin
            dwell   <= dwell + DWELL_W'(1);
        end
    end

    // Classify the current column sample and fold it into the running scan.
    always_comb begin
        sample    = (dwell == DWELL_LAST);
        lows      = ~row_sync;
        col_keys  = 3'(lows[0]) + 3'(lows[1]) + 3'(lows[2]) + 3'(lows[3]);
        row_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (lows[i]) row_idx = 2'(i);
        end
        base_keys = (col_idx == 2'd0) ? 2'd0 : acc_keys;
        sum_keys  = 3'(base_keys) + col_keys;
        scan_keys = (sum_keys >= 3'd2) ? 2'd2 : 2'(sum_keys);
        if (col_keys == 3'd1) begin
            scan_code = keymap(row_idx, col_idx);
        end else if (col_idx == 2'd0) begin
            scan_code = 4'h0;
        end else begin
            scan_code = acc_code;
        end
        case (scan_keys)
            2'd0:    scan_kind = RES_NONE;
            2'd1:    scan_kind = RES_ONE;
            default: scan_kind = RES_MULTI;
        endcase
    end

    // Accumulate per column; publish the scan result after column 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_keys <= 2'd0;
            acc_code <= 4'h0;
            result   <= '0;
        end else begin
            result.valid <= 1'b0;
            if (sample) begin
                acc_keys <= scan_keys;
                acc_code <= scan_code;
                if (col_idx == 2'd3) begin
                    result.valid <= 1'b1;
                    result.kind  <= scan_kind;
                    result.code  <= (scan_kind == RES_ONE) ? scan_code : 4'h0;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_decoder.sv
// keypad_decoder: scans a 4x4 keypad and debounces whole scans into one
// key_valid strobe per clean press. Optional feature macro:
// KEYPAD_AUTOREPEAT_EN repeats the strobe every REPEAT_SCANS scans while held.
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES    = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] decode,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    scan_result_t   result;
    db_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]     cand_q, cand_d;
    logic [3:0]     decode_d;
    logic           key_valid_d;
    logic           key_held_d;
    logic           count_done;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_SCANS + 1);
    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_done;
    assign rep_done = (32'(rep_q) + 32'd1) >= REPEAT_SCANS;

    // Scans-held counter between repeat strobes.
    always_ff @(posedge clk) begin
        if (rst) rep_q <= '0;
        else     rep_q <= rep_d;
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_SCANS;
`endif

    keypad_scanner #(
        .SCAN_CYCLES (SCAN_CYCLES)
    ) u_scanner (
        .clk    (clk),
        .rst    (rst),
        .row    (row),
        .col    (col),
        .result (result)
    );

    assign count_done = (32'(count_q) + 32'd1) >= DEBOUNCE_SCANS;

    // Debounce state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            cand_q    <= 4'h0;
            decode    <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            cand_q    <= cand_d;
            decode    <= decode_d;
            key_valid <= key_valid_d;
            key_held  <= key_held_d;
        end
    end

    // Debounce next-state: advance only on a published scan result.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        cand_d      = cand_q;
        decode_d    = decode;
        key_valid_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d       = rep_q;
`endif
        if (result.valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (result.kind == RES_ONE) begin
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_d     = ST_HELD;
                            count_d     = '0;
                            decode_d    = result.code;
                            key_valid_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d       = '0;
`endif
                        end else begin
                            state_d = ST_CAND;
                            cand_d  = result.code;
                            count_d = CNT_W'(1);
                        end
                    end
                end
                ST_CAND: begin
                    if (result.kind == RES_ONE && result.code == cand_q) begin
                        if (count_done) begin
                            state_d     = ST_HELD;
                            count_d     = '0;
                            decode_d    = cand_q;
                            key_valid_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d       = '0;
`endif
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                end
                ST_HELD: begin
                    if (result.kind == RES_NONE) begin
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_d = ST_IDLE;
                            count_d = '0;
                        end else begin
                            state_d = ST_REL;
                            count_d = CNT_W'(1);
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d = '0;
                    end else if (result.kind == RES_ONE) begin
                        if (rep_done) begin
                            rep_d       = '0;
                            key_valid_d = 1'b1;
                        end else begin
                            rep_d = rep_q + REP_W'(1);
                        end
                    end else begin
                        rep_d = '0;
`endif
                    end
                end
                default: begin
                    if (result.kind == RES_NONE) begin
                        if (count_done) begin
                            state_d = ST_IDLE;
                            count_d = '0;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_HELD;
                        count_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d   = '0;
`endif
                    end
                end
            endcase
        end
        key_held_d = (state_d == ST_HELD) || (state_d == ST_REL);
    end

endmodule

// File: doc/keypad_decoder.md
# keypad_decoder

- Sits directly upstream of the game FSM.
- Scans the 4×4 Pmod keypad (drives columns, samples rows) and debounces each complete scan.
- For each clean press, emits exactly one 4-bit key code (`decode`) with a single-cycle strobe.
- The game FSM consumes `decode`: 1–4 select operands, A/B/C/D select operators.

## Interface
- `SCAN_CYCLES`, default 100000: clock cycles each column is held driven (1 ms at 100 MHz); minimum 2.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required to accept a press or a release; minimum 1.
- `REPEAT_SCANS`, default 250: full scans between repeat strobes while a key is held (used only with autorepeat).
- `clk`  in  1  system clock; one clock.
- `rst`  in  1  reset, synchronous, active-high.
- `row`  in  4  keypad rows, active-low, pulled up externally; `row[0]` is the top row.
- `col`  out  4  keypad columns, one driven low at a time; `col[0]` is the leftmost column.
- `decode`  out  4  hex code of the accepted key.
- `key_valid`  out  1  one-cycle strobe; `decode` is new or repeated on this cycle.
- `key_held`  out  1  high while an accepted key remains pressed.

## Operation
- Keymap, rows top→bottom, columns left→right: `1 2 3 A` / `4 5 6 B` / `7 8 9 C` / `0 F E D`.
- `decode` equals the key's hex value. `0` is `4'h0` and is distinguished from "no key" only by `key_valid`.
- Scanner:
  - Column index `c` cycles 0→1→2→3→0; `col = ~(4'b0001 << c)`.
  - Dwell counter runs 0..`SCAN_CYCLES-1`.
  - `row` is sampled on the last dwell cycle of each column, after settling.
  - At the end of column 3 the scanner publishes the scan result for one cycle: NONE (no row low), ONE(code) (exactly one key low in the whole scan), or MULTI (two or more keys).
- Debounce FSM states:
  - IDLE: a ONE(k) result → CAND with candidate k, count=1.
  - CAND: ONE(k) again → count+1. Any other result → IDLE. When count reaches `DEBOUNCE_SCANS` → HELD; latch `decode=k`, pulse `key_valid`. With `DEBOUNCE_SCANS=1`, IDLE goes straight to HELD.
  - HELD: `key_held=1`. NONE → REL with count=1. ONE(k) or MULTI stays HELD; a second key never generates a press.
  - REL: NONE → count+1; at `DEBOUNCE_SCANS` → IDLE with `key_held=0`. Any key seen → HELD, count cleared.
- MULTI never produces a press. Rolling from key X to key Y requires a full release first.
- `decode` holds its last accepted value until the next acceptance.
- Reset values: `col=4'b1110`, `decode=4'h0`, `key_valid=0`, `key_held=0`, FSM=IDLE, dwell and scan counters=0.

## Timing
- Full scan = 4·`SCAN_CYCLES` cycles. Scan result is valid the cycle after the column-3 sample edge.
- `key_valid` asserts the cycle after the `DEBOUNCE_SCANS`-th matching scan result.
  - Worst-case press latency from a stable press ≈ (`DEBOUNCE_SCANS`+1)·4·`SCAN_CYCLES`+2 cycles.
- `key_valid` is high exactly one cycle per acceptance, never on two consecutive cycles.
- `rst` on any edge, including mid-scan or in HELD, returns all state to reset values on the next cycle with no `key_valid`.
  - A key still held after reset is re-detected and re-accepted by normal debounce.
- `row` is asynchronous. It passes through a two-flop synchronizer inside the scanner; sample timing is referenced to the synchronized value, which is the reason `SCAN_CYCLES` ≥ 2.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined: in HELD, a scan counter increments per ONE(k) result. Every `REPEAT_SCANS` results, `key_valid` pulses again with `decode` unchanged; the counter clears on entry to HELD and on any non-ONE result.
- Not defined: exactly one `key_valid` per press; `REPEAT_SCANS` is ignored and no repeat logic is synthesized.

## Structure
- Package `keypad_pkg`:
  - key code constants: `KEY_ADD=4'hA`, `KEY_SUB=4'hB`, `KEY_DIV=4'hC`, `KEY_MUL=4'hD`;
  - scan-result encoding (NONE/ONE/MULTI);
  - debounce state encoding;
  - keymap function (row,col)→code.
- Sub-module `keypad_scanner`: column drive, dwell counter, row synchronizer, per-scan result. `keypad_decoder` holds the debounce FSM and outputs.

## Test plan
All cases use `SCAN_CYCLES=4`, `DEBOUNCE_SCANS=2`.
- Reset: assert `rst` 3 cycles → `col=4'b1110`, `decode=0`, `key_valid=0`, `key_held=0`. `col` walks `1101`, `1011`, `0111` at 4-cycle intervals.
- Press key `5` (`row[1]` low while `col[1]` low), held steady → exactly one `key_valid` with `decode=4'h5` after the 2nd full scan, `key_held=1`.
  - Release → `key_held=0` after 2 empty scans, with no further strobe.
- Bounce: key `3` present on alternating scans for 10 scans → no `key_valid`; `decode` stays 0.
- Keys `1` and `D` together for 5 scans → no strobe. Release both, then press `D` alone → one strobe, `decode=4'hD`.
- Hold `A`, strobe seen; assert `rst` mid-column while `A` is still held → outputs clear, then one new `A` strobe after 2 scans.
- With `KEYPAD_AUTOREPEAT_EN`, `REPEAT_SCANS=3`: hold `4` for 11 scans → strobes at acceptance and every 3 scans thereafter (4 total), all with `decode=4'h4`.
